// File: rtl/alexander_pd_pkg.sv
// Shared types and sizing helpers for the Alexander (bang-bang) phase detector.
//   lane_dec_t : per-lane early/late classification
//   vote_width : signed width able to hold +/- nlane*win without overflow
package alexander_pd_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    UP     = 2'd1,
    DN     = 2'd2,
    GLITCH = 2'd3
  } lane_dec_t;

  function automatic int vote_width(input int nlane, input int win);
    return $clog2(nlane * win + 1) + 1;
  endfunction

endpackage

// File: rtl/bbpd_lane_decode.sv
// Single-lane Alexander decode (combinational).
//   d_prev : data sample preceding the edge sample
//   d_cur  : data sample following the edge sample
//   e      : edge sample between d_prev and d_cur
//   dec    : UP (clock late), DN (clock early), GLITCH (edge error with no
//            transition) or NONE
module bbpd_lane_decode
  import alexander_pd_pkg::*;
(
  input  logic      d_prev,
  input  logic      d_cur,
  input  logic      e,
  output lane_dec_t dec
);

  always_comb begin
    dec = NONE;
    if (d_prev != d_cur) begin
      // On a transition e matches exactly one neighbour.
      dec = (e == d_cur) ? UP : DN;
    end else if (e != d_cur) begin
      dec = GLITCH;
    end
  end

endmodule

// File: rtl/alexander_pd_nlane.sv
// Deserialised NLANE-wide Alexander phase detector.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : qualifies dsample/esample
//   dsample    : NLANE data samples, bit 0 oldest
//   esample    : NLANE edge samples, esample[i] between d[i-1] and d[i]
//   up, dn     : one-cycle decision pulses at window close
//   vote       : signed window sum, held between decisions
//   vote_valid : one-cycle strobe qualifying vote/up/dn
//   glitch_cnt : saturating count of non-transition edge errors
// Pipeline: input regs -> registered per-word popcounts -> window/output regs,
// so a word sampled at edge k shows up on the outputs after edge k+2.
module alexander_pd_nlane
  import alexander_pd_pkg::*;
#(
  parameter  int NLANE    = 4,
  parameter  int WIN      = 8,
  parameter  int DEADBAND = 0,
  parameter  int GW       = 16,
  localparam int VW       = vote_width(NLANE, WIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NLANE-1:0]     dsample,
  input  logic [NLANE-1:0]     esample,
  output logic                 up,
  output logic                 dn,
  output logic signed [VW-1:0] vote,
  output logic                 vote_valid,
  output logic [GW-1:0]        glitch_cnt
);

  localparam int STAGES = 1;
  localparam int CW     = $clog2(NLANE + 1);
  localparam int WW     = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int SW     = ((GW > CW) ? GW : CW) + 1;
  localparam logic [GW-1:0]        GMAX = '1;
  localparam logic [WW-1:0]        WLAST = WW'(WIN - 1);
  localparam logic signed [VW-1:0] DBP  = VW'(DEADBAND);
  localparam logic signed [VW-1:0] DBN  = -DBP;

  // vld_pipe[0]: stage-1 word valid, vld_pipe[1]: stage-2 popcounts valid
  logic [STAGES:0]     vld_pipe;
  logic                d_last;
  logic                s1_dprev;
  logic [NLANE-1:0]    s1_d, s1_e;

  // ---------------- stage 1: capture word, carry boundary bit ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      d_last   <= 1'b0;
      s1_dprev <= 1'b0;
      s1_d     <= '0;
      s1_e     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (in_valid) begin
        s1_d     <= dsample;
        s1_e     <= esample;
        s1_dprev <= d_last;
        d_last   <= dsample[NLANE-1];
      end
    end
  end

  // ---------------- lane decode ----------------
  lane_dec_t dec [NLANE];

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic dp;
    if (i == 0) begin : g_first
      assign dp = s1_dprev;
    end else begin : g_rest
      assign dp = s1_d[i-1];
    end
    bbpd_lane_decode u_dec (
      .d_prev (dp),
      .d_cur  (s1_d[i]),
      .e      (s1_e[i]),
      .dec    (dec[i])
    );
  end

  logic [CW-1:0]        nup, ndn, ng_c;
  logic signed [VW-1:0] wv_c;

  always_comb begin
    nup  = '0;
    ndn  = '0;
    ng_c = '0;
    for (int i = 0; i < NLANE; i++) begin
      nup  = nup  + CW'(dec[i] == UP);
      ndn  = ndn  + CW'(dec[i] == DN);
      ng_c = ng_c + CW'(dec[i] == GLITCH);
    end
    wv_c = $signed(VW'(nup)) - $signed(VW'(ndn));
  end

  // ---------------- stage 2: register per-word results ----------------
  logic signed [VW-1:0] s2_wv;
  logic [CW-1:0]        s2_ng;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_wv <= '0;
      s2_ng <= '0;
    end else if (vld_pipe[0]) begin
      s2_wv <= wv_c;
      s2_ng <= ng_c;
    end
  end

  // ---------------- window accumulation and outputs ----------------
  logic signed [VW-1:0] acc, acc_nxt;
  logic [WW-1:0]        wcnt;
  logic [SW-1:0]        gsum;
  logic [GW-1:0]        gsat;

  always_comb begin
    acc_nxt = acc + s2_wv;
    gsum    = SW'(glitch_cnt) + SW'(s2_ng);
    gsat    = (gsum > SW'(GMAX)) ? GMAX : gsum[GW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      wcnt       <= '0;
      vote       <= '0;
      vote_valid <= 1'b0;
      up         <= 1'b0;
      dn         <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      vote_valid <= 1'b0;
      up         <= 1'b0;
      dn         <= 1'b0;
      if (vld_pipe[STAGES]) begin
        glitch_cnt <= gsat;
        if (wcnt == WLAST) begin
          // Closing word is folded in here so nothing is lost at the boundary.
          vote       <= acc_nxt;
          vote_valid <= 1'b1;
          up         <= (acc_nxt > DBP);
          dn         <= (acc_nxt < DBN);
          acc        <= '0;
          wcnt       <= '0;
        end else begin
          acc  <= acc_nxt;
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alexander_pd_nlane.sv
// Bench for alexander_pd_nlane: three instances (baseline, DEADBAND=3, GW=3)
// share one stimulus stream and are each compared every cycle against a
// behavioural model, plus constant checks on the directed scenarios.
module tb_alexander_pd_nlane;

  localparam int NL = 4;
  localparam int WN = 2;

  logic clk = 1'b0;
  logic rst, in_valid;
  logic [NL-1:0] dsample, esample;

  logic              up_w [3];
  logic              dn_w [3];
  logic              vv_w [3];
  logic signed [4:0] vote_w [3];
  logic [15:0]       g0, g1;
  logic [2:0]        g2;

  always #5 clk = ~clk;

  alexander_pd_nlane #(.NLANE(NL), .WIN(WN), .DEADBAND(0), .GW(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dsample(dsample), .esample(esample),
    .up(up_w[0]), .dn(dn_w[0]), .vote(vote_w[0]), .vote_valid(vv_w[0]), .glitch_cnt(g0));
  alexander_pd_nlane #(.NLANE(NL), .WIN(WN), .DEADBAND(3), .GW(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dsample(dsample), .esample(esample),
    .up(up_w[1]), .dn(dn_w[1]), .vote(vote_w[1]), .vote_valid(vv_w[1]), .glitch_cnt(g1));
  alexander_pd_nlane #(.NLANE(NL), .WIN(WN), .DEADBAND(0), .GW(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dsample(dsample), .esample(esample),
    .up(up_w[2]), .dn(dn_w[2]), .vote(vote_w[2]), .vote_valid(vv_w[2]), .glitch_cnt(g2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int vv;
    int vote;
    int up;
    int dn;
    int g;
  } res_t;

  int   m_db   [3] = '{0, 3, 0};
  int   m_gmax [3] = '{65535, 65535, 7};
  int   m_dlast[3];
  int   m_sum  [3];
  int   m_cnt  [3];
  int   m_g    [3];
  res_t p1[3], p2[3], o[3];

  function automatic int g_of(input int c);
    return (c == 0) ? int'(g0) : (c == 1) ? int'(g1) : int'(g2);
  endfunction

  // Called once per rising edge with the inputs that edge sampled.
  task automatic model_step(input int c, input logic r, input logic v,
                            input logic [NL-1:0] d, input logic [NL-1:0] e);
    res_t z, res;
    int   wv, ng, prev;
    z = '{0, 0, 0, 0, 0};
    if (r) begin
      m_dlast[c] = 0; m_sum[c] = 0; m_cnt[c] = 0; m_g[c] = 0;
      p1[c] = z; p2[c] = z; o[c] = z;
      return;
    end
    res = '{0, 0, 0, 0, m_g[c]};
    if (v) begin
      wv = 0; ng = 0;
      for (int i = 0; i < NL; i++) begin
        prev = (i == 0) ? m_dlast[c] : int'(d[i-1]);
        if (prev != int'(d[i])) wv += (e[i] == d[i]) ? 1 : -1;
        else if (e[i] != d[i])  ng++;
      end
      m_dlast[c] = int'(d[NL-1]);
      m_g[c]     = (m_g[c] + ng > m_gmax[c]) ? m_gmax[c] : m_g[c] + ng;
      m_sum[c]  += wv;
      m_cnt[c]++;
      if (m_cnt[c] == WN) begin
        res.vv   = 1;
        res.vote = m_sum[c];
        res.up   = (m_sum[c] >  m_db[c]) ? 1 : 0;
        res.dn   = (m_sum[c] < -m_db[c]) ? 1 : 0;
        m_sum[c] = 0;
        m_cnt[c] = 0;
      end
      res.g = m_g[c];
    end
    // Outputs after this edge reflect the word sampled two edges earlier.
    o[c].vv = p2[c].vv;
    o[c].up = p2[c].up;
    o[c].dn = p2[c].dn;
    o[c].g  = p2[c].g;
    if (p2[c].vv != 0) o[c].vote = p2[c].vote;
    p2[c] = p1[c];
    p1[c] = res;
  endtask

  task automatic cycle(input logic r, input logic v,
                       input logic [NL-1:0] d, input logic [NL-1:0] e);
    rst = r; in_valid = v; dsample = d; esample = e;
    @(posedge clk);
    for (int c = 0; c < 3; c++) model_step(c, r, v, d, e);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("vv%0d",   c), int'(vv_w[c]),  o[c].vv);
      chk($sformatf("up%0d",   c), int'(up_w[c]),  o[c].up);
      chk($sformatf("dn%0d",   c), int'(dn_w[c]),  o[c].dn);
      chk($sformatf("vote%0d", c), int'(vote_w[c]), o[c].vote);
      chk($sformatf("gcnt%0d", c), g_of(c),        o[c].g);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, NL'($urandom), NL'($urandom));
  endtask

  task automatic rstc(input int n);
    repeat (n) cycle(1'b1, 1'($urandom), NL'($urandom), NL'($urandom));
  endtask

  task automatic word(input logic [NL-1:0] d, input logic [NL-1:0] e);
    cycle(1'b0, 1'b1, d, e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; dsample = '0; esample = '0;

    // reset with random inputs
    rstc(3);
    chk("rst_vv", int'(vv_w[0]), 0);
    chk("rst_vote", int'(vote_w[0]), 0);
    chk("rst_gcnt", int'(g0), 0);

    // late clock: +3 then +4
    word(4'b1010, 4'b1010);
    word(4'b1010, 4'b1010);
    idle(1);
    chk("late_vv_early", int'(vv_w[0]), 0);
    idle(1);
    chk("late_vote", int'(vote_w[0]), 7);
    chk("late_up",   int'(up_w[0]), 1);
    chk("late_dn",   int'(dn_w[0]), 0);
    chk("late_vv",   int'(vv_w[0]), 1);
    idle(1);
    chk("late_pulse_end", int'(vv_w[0]) + int'(up_w[0]), 0);

    // early clock: -3 then -4
    rstc(1);
    word(4'b1010, 4'b0100);
    word(4'b1010, 4'b0101);
    idle(2);
    chk("early_vote", int'(vote_w[0]), -7);
    chk("early_dn",   int'(dn_w[0]), 1);
    chk("early_up",   int'(up_w[0]), 0);

    // balanced window {+3,-3}
    rstc(1);
    word(4'b1010, 4'b1010);
    word(4'b0101, 4'b1011);
    idle(2);
    chk("bal_vote", int'(vote_w[0]), 0);
    chk("bal_vv",   int'(vv_w[0]), 1);
    chk("bal_updn", int'(up_w[0]) + int'(dn_w[0]), 0);

    // deadband 3: {+3,+1} fires, {+3,0} does not
    rstc(1);
    word(4'b1010, 4'b1010);
    word(4'b0101, 4'b0001);
    idle(2);
    chk("db_vote4", int'(vote_w[1]), 4);
    chk("db_up4",   int'(up_w[1]), 1);
    word(4'b1010, 4'b1010);
    word(4'b1111, 4'b1111);
    idle(2);
    chk("db_vote3", int'(vote_w[1]), 3);
    chk("db_vv3",   int'(vv_w[1]), 1);
    chk("db_up3",   int'(up_w[1]) + int'(dn_w[1]), 0);
    chk("nodb_up3", int'(up_w[0]), 1);

    // glitch saturation at GW=3: 2, 4, 6, 7, hold
    rstc(1);
    word(4'b0000, 4'b0101);
    word(4'b0000, 4'b0101);
    word(4'b0000, 4'b0101);
    chk("gl_2", int'(g2), 2);
    word(4'b0000, 4'b0101);
    chk("gl_4", int'(g2), 4);
    idle(1);
    chk("gl_6", int'(g2), 6);
    idle(1);
    chk("gl_7", int'(g2), 7);
    chk("gl_8_wide", int'(g0), 8);
    chk("gl_vote", int'(vote_w[2]), 0);
    word(4'b0000, 4'b0101);
    idle(2);
    chk("gl_hold", int'(g2), 7);
    chk("gl_10_wide", int'(g0), 10);

    // gap inside a window
    rstc(1);
    word(4'b1010, 4'b1010);
    idle(5);
    chk("gap_novv", int'(vv_w[0]), 0);
    word(4'b1010, 4'b1010);
    idle(2);
    chk("gap_vote", int'(vote_w[0]), 7);
    chk("gap_up",   int'(up_w[0]), 1);

    // mid-window reset drops the pending word
    word(4'b1010, 4'b1010);
    rstc(1);
    word(4'b1010, 4'b0100);
    word(4'b0101, 4'b1011);
    idle(2);
    chk("mrst_vote", int'(vote_w[0]), -6);
    chk("mrst_dn",   int'(dn_w[0]), 1);

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 70),
            NL'($urandom), NL'($urandom));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
